// File: rtl/rhd_spi_sampler_pkg.sv
// ============================================================================
// Module      : rhd_pkg
// Description : Shared constants, FSM state encoding and command helpers for
//               the RHD2000 SPI sampling engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rhd_pkg;

  // RHD2000 command words
  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_DUMMY     = 16'hE800;  // READ(40)
  localparam logic [1:0]  CONVERT_OP    = 2'b00;

  // The chip returns the result of command k during frame k+2
  localparam int RHD_PIPE_DEPTH = 2;
  // Dummy frames the chip needs after CALIBRATE
  localparam int CALIB_DUMMIES  = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_GAP   = 2'd3
  } rhd_state_e;

  function automatic logic [15:0] convert_cmd(input logic [5:0] ch);
    return {CONVERT_OP, ch, 8'h00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rhd_spi_sampler_if.sv
// ============================================================================
// Module      : rhd_spi_sampler_if
// Description : Sample stream (valid/ready) carrying one 16-bit RHD result
//               tagged with its channel index and an end-of-sweep marker.
//               master : m_data, m_ch, m_last, m_valid out; m_ready in
//               slave  : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rhd_spi_sampler_if;
  logic [15:0] m_data;
  logic [5:0]  m_ch;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  modport master (output m_data, m_ch, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_ch, m_last, m_valid, output m_ready);
endinterface

`default_nettype wire

// File: rtl/rhd_spi_sampler_frame.sv
// ============================================================================
// Module      : rhd_spi_frame
// Description : Full-duplex 16-bit SPI frame engine (CPOL=0, registered SCK).
//               CS falls with MOSI = bit 15, CLK_DIV setup cycles, 16 SCK
//               periods (CLK_DIV low / CLK_DIV high), then CS high for
//               CS_HIGH cycles. Back-to-back frames while start is high.
// Ports       : clk, rst_n        - clock, async active-low reset
//               start             - request another frame (level)
//               tx_word           - command, latched at CS fall
//               miso              - serial data from the chip
//               cs, sck, mosi     - registered SPI pins
//               rx_word           - received word
//               done              - one-cycle pulse, rx_word complete; the
//                                   following edge ends the frame
//               active            - engine not idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rhd_spi_frame
  import rhd_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_HIGH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic [15:0] tx_word,
  input  wire logic        miso,
  output logic             cs,
  output logic             sck,
  output logic             mosi,
  output logic [15:0]      rx_word,
  output logic             done,
  output logic             active
);

  localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(CS_HIGH - 1);

  rhd_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    bit_idx, bit_idx_nx;
  logic [15:0]   tx_sr, tx_sr_nx;
  logic [15:0]   rx_sr, rx_sr_nx;
  logic          cs_nx, sck_nx;
  logic          tick, last_bit;

  assign tick     = (cnt == '0);          // last cycle of the current segment
  assign last_bit = (bit_idx == 4'd0);
  assign mosi     = tx_sr[15];
  assign rx_word  = rx_sr;
  assign active   = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      cs      <= 1'b1;
      sck     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      tx_sr   <= tx_sr_nx;
      rx_sr   <= rx_sr_nx;
      cs      <= cs_nx;
      sck     <= sck_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_CS_SETUP;
      ST_CS_SETUP: if (tick) state_nx = ST_SHIFT;
      ST_SHIFT:    if (tick && sck && last_bit) state_nx = ST_CS_GAP;
      ST_CS_GAP:   if (tick) state_nx = start ? ST_CS_SETUP : ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_nx     = tick ? cnt : cnt - 1'b1;
    bit_idx_nx = bit_idx;
    tx_sr_nx   = tx_sr;
    rx_sr_nx   = rx_sr;
    cs_nx      = cs;
    sck_nx     = sck;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cs_nx    = 1'b0;
          tx_sr_nx = tx_word;
          cnt_nx   = DIV_LOAD;
        end
      end
      ST_CS_SETUP: begin
        if (tick) begin
          cnt_nx     = DIV_LOAD;
          bit_idx_nx = 4'd15;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          cnt_nx = DIV_LOAD;
          if (!sck) begin
            // Rising SCK: capture MISO
            sck_nx   = 1'b1;
            rx_sr_nx = {rx_sr[14:0], miso};
          end else begin
            // Falling SCK: advance MOSI, or end the frame after bit 0
            sck_nx = 1'b0;
            if (last_bit) begin
              done     = 1'b1;
              cs_nx    = 1'b1;
              tx_sr_nx = '0;
              cnt_nx   = GAP_LOAD;
            end else begin
              bit_idx_nx = bit_idx - 1'b1;
              tx_sr_nx   = {tx_sr[14:0], 1'b0};
            end
          end
        end
      end
      ST_CS_GAP: begin
        if (tick && start) begin
          cs_nx    = 1'b0;
          tx_sr_nx = tx_word;
          cnt_nx   = DIV_LOAD;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rhd_spi_sampler.sv
// ============================================================================
// Module      : rhd_spi_sampler
// Description : RHD2000 sampling engine. Sweeps NUM_CH channels with CONVERT
//               commands plus two trailing dummy reads, realigns the chip's
//               two-frame result pipeline and streams channel-tagged samples.
//               Optional macro RHD_CALIB_EN: first run after reset is
//               preceded by CALIBRATE and 9 dummy frames.
// Ports       : sysclk, sys_rst_n - clock, async active-low reset
//               adc_en            - run sweeps while high
//               rhd_miso          - chip serial data
//               rhd_cs/sck/mosi   - chip SPI pins
//               m                 - sample stream (master)
//               overflow          - sticky, a sample was dropped
//               busy              - frame engine active
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rhd_spi_sampler
  import rhd_pkg::*;
#(
  parameter int NUM_CH  = 32,
  parameter int CLK_DIV = 2,
  parameter int CS_HIGH = 8
) (
  input  wire logic         sysclk,
  input  wire logic         sys_rst_n,
  input  wire logic         adc_en,
  input  wire logic         rhd_miso,
  output logic              rhd_cs,
  output logic              rhd_sck,
  output logic              rhd_mosi,
  rhd_spi_sampler_if.master m,
  output logic              overflow,
  output logic              busy
);

  localparam logic [6:0] NUM_CH_W     = 7'(NUM_CH);
  localparam logic [6:0] LAST_FRAME   = 7'(NUM_CH + RHD_PIPE_DEPTH - 1);
  localparam logic [6:0] FIRST_RESULT = 7'(RHD_PIPE_DEPTH);

  logic [6:0]  frame;        // index of the sweep frame in flight
  logic [15:0] tx_word, rx_word;
  logic        frame_done, active, start, mid_seq, in_calib, word_done;

  rhd_spi_frame #(
    .CLK_DIV (CLK_DIV),
    .CS_HIGH (CS_HIGH)
  ) u_frame (
    .clk     (sysclk),
    .rst_n   (sys_rst_n),
    .start   (start),
    .tx_word (tx_word),
    .miso    (rhd_miso),
    .cs      (rhd_cs),
    .sck     (rhd_sck),
    .mosi    (rhd_mosi),
    .rx_word (rx_word),
    .done    (frame_done),
    .active  (active)
  );

`ifdef RHD_CALIB_EN
  logic [3:0] calib_cnt;
  logic       calib_pending;   // set by reset only, so calibration runs once

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      calib_pending <= 1'b1;
      calib_cnt     <= '0;
    end else if (frame_done && calib_pending) begin
      if (calib_cnt == 4'(CALIB_DUMMIES)) begin
        calib_pending <= 1'b0;
        calib_cnt     <= '0;
      end else begin
        calib_cnt <= calib_cnt + 1'b1;
      end
    end
  end

  assign in_calib = calib_pending;
  // A started calibration sequence always runs to the end
  assign mid_seq  = (frame != '0) || (calib_pending && calib_cnt != '0);
`else
  assign in_calib = 1'b0;
  assign mid_seq  = (frame != '0);
`endif

  // A sweep in progress always finishes, regardless of adc_en
  assign start = adc_en || mid_seq;

  always_comb begin
    tx_word = (frame < NUM_CH_W) ? convert_cmd(frame[5:0]) : CMD_DUMMY;
`ifdef RHD_CALIB_EN
    if (calib_pending) tx_word = (calib_cnt == '0) ? CMD_CALIBRATE : CMD_DUMMY;
`endif
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame <= '0;
    end else if (frame_done && !in_calib) begin
      frame <= (frame == LAST_FRAME) ? '0 : frame + 1'b1;
    end
  end

  // The first RHD_PIPE_DEPTH frames of a sweep carry stale results
  assign word_done = frame_done && !in_calib && (frame >= FIRST_RESULT);
  assign busy      = active;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m.m_data  <= '0;
      m.m_ch    <= '0;
      m.m_last  <= 1'b0;
      m.m_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (word_done && !(m.m_valid && !m.m_ready)) begin
        m.m_data  <= rx_word;
        m.m_ch    <= 6'(frame - FIRST_RESULT);
        m.m_last  <= (frame == LAST_FRAME);
        m.m_valid <= 1'b1;
      end else if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
      end

      if (word_done && m.m_valid && !m.m_ready) begin
        overflow <= 1'b1;
      end else if (!active) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rhd_spi_sampler.sv
// ============================================================================
// Module      : tb_rhd_spi_sampler
// Description : Directed bench for rhd_spi_sampler. Instance A uses default
//               parameters with an RHD pipeline model (CONVERT(ch) returns
//               16'h8000+ch); instance B uses NUM_CH=4, CLK_DIV=1, CS_HIGH=1
//               with MISO tied high for waveform timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rhd_spi_sampler;

`ifdef RHD_CALIB_EN
  localparam int CAL = 10;
`else
  localparam int CAL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A (defaults) ----------------
  logic a_adc_en = 1'b0;
  logic a_miso = 1'b0;
  logic a_cs, a_sck, a_mosi, a_ovf, a_busy;
  rhd_spi_sampler_if ia ();

  rhd_spi_sampler #(.NUM_CH(32), .CLK_DIV(2), .CS_HIGH(8)) dut_a (
    .sysclk(clk), .sys_rst_n(rst_n), .adc_en(a_adc_en), .rhd_miso(a_miso),
    .rhd_cs(a_cs), .rhd_sck(a_sck), .rhd_mosi(a_mosi), .m(ia.master),
    .overflow(a_ovf), .busy(a_busy));

  function automatic logic [15:0] rhd_resp(input logic [15:0] c);
    return (c[15:14] == 2'b00) ? 16'h8000 + {10'd0, c[13:8]} : 16'h1234;
  endfunction

  logic [15:0] a_cmd = '0, a_send = '0, a_res1 = '0, a_msr = '0;
  logic a_pcs = 1'b1, a_psck = 1'b0;
  logic [15:0] a_frames[$];
  int          a_falls[$];
  logic [22:0] a_words[$];   // {last, ch, data}

  // RHD model: result of command k is shifted out during frame k+2
  always @(negedge clk) begin
    if (a_pcs && !a_cs) begin
      a_msr = a_send;
      a_falls.push_back(cyc);
    end else if (a_psck && !a_sck) begin
      a_msr = {a_msr[14:0], 1'b0};
    end
    if (!a_psck && a_sck) a_cmd = {a_cmd[14:0], a_mosi};
    if (!a_pcs && a_cs) begin
      a_send = a_res1;
      a_res1 = rhd_resp(a_cmd);
      a_frames.push_back(a_cmd);
    end
    if (ia.m_valid && ia.m_ready) a_words.push_back({ia.m_last, ia.m_ch, ia.m_data});
    a_miso = a_msr[15];
    a_pcs  = a_cs;
    a_psck = a_sck;
  end

  // ---------------- instance B (fast timing) ----------------
  logic b_adc_en = 1'b0;
  logic b_miso = 1'b1;
  logic b_cs, b_sck, b_mosi, b_ovf, b_busy;
  rhd_spi_sampler_if ib ();

  rhd_spi_sampler #(.NUM_CH(4), .CLK_DIV(1), .CS_HIGH(1)) dut_b (
    .sysclk(clk), .sys_rst_n(rst_n), .adc_en(b_adc_en), .rhd_miso(b_miso),
    .rhd_cs(b_cs), .rhd_sck(b_sck), .rhd_mosi(b_mosi), .m(ib.master),
    .overflow(b_ovf), .busy(b_busy));

  logic [15:0] b_cmd = '0;
  int          b_np = 0;
  logic        b_pcs = 1'b1, b_psck = 1'b0;
  logic [20:0] b_frames[$];  // {sck pulses, mosi word}
  int          b_falls[$], b_rises[$];
  logic [23:0] b_outs[$];    // {valid, last, ch, data} right after CS rise

  always @(negedge clk) begin
    if (b_pcs && !b_cs) begin
      b_falls.push_back(cyc);
      b_np = 0;
    end
    if (!b_psck && b_sck) begin
      b_cmd = {b_cmd[14:0], b_mosi};
      b_np++;
    end
    if (!b_pcs && b_cs) begin
      b_rises.push_back(cyc);
      b_frames.push_back({5'(b_np), b_cmd});
      b_outs.push_back({ib.m_valid, ib.m_last, ib.m_ch, ib.m_data});
    end
    b_pcs  = b_cs;
    b_psck = b_sck;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ia.m_ready = 1'b1;
    ib.m_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 32'({a_cs, a_sck, a_mosi, ia.m_valid, ia.m_last, a_ovf, a_busy}), 32'h40);
    chk("rst_data", 32'({ia.m_ch, ia.m_data}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- B: waveform at CLK_DIV=1, CS_HIGH=1 ----
    b_adc_en = 1'b1;
    for (int i = 0; i < 3000 && b_rises.size() < CAL + 7; i++) @(negedge clk);
    b_adc_en = 1'b0;
    chk("b_frames_timeout", 32'(b_rises.size() >= CAL + 7), 1);
    chk("b_sck_pulses", 32'(b_frames[CAL+3][20:16]), 16);
    chk("b_mosi_ch3", 32'(b_frames[CAL+3][15:0]), 'h0300);
    chk("b_mosi_dummy", 32'(b_frames[CAL+4][15:0]), 'hE800);
    chk("b_mosi_wrap", 32'(b_frames[CAL+6][15:0]), 0);
    chk("b_period", 32'(b_falls[CAL+4] - b_falls[CAL+3]), 34);
    chk("b_cs_gap", 32'(b_falls[CAL+4] - b_rises[CAL+3]), 1);
    chk("b_valid_ch0", 32'(b_outs[CAL+2]), 'h80FFFF);
    chk("b_valid_ch3_last", 32'(b_outs[CAL+5]), 'hC3FFFF);
    for (int i = 0; i < 1000 && b_busy; i++) @(negedge clk);
    chk("b_idle", 32'(b_busy), 0);

    // ---- A: full sweeps, then adc_en drop in frame 5 ----
    @(negedge clk);
    a_adc_en = 1'b1;
    @(posedge clk);
    #1;
    chk("a_first_cs_fall", 32'(a_cs), 0);
    for (int i = 0; i < 10000 && a_words.size() < 32; i++) @(negedge clk);
    chk("a_words_timeout", 32'(a_words.size() >= 32), 1);
    for (int i = 0; i < 32; i++)
      chk($sformatf("a_word%0d", i), 32'(a_words[i]),
          32'({(i == 31), 6'(i), 16'(16'h8000 + i)}));
    for (int i = 0; i < 5000 && a_falls.size() < CAL + 40; i++) @(negedge clk);
    a_adc_en = 1'b0;
    for (int i = 0; i < 5000 && a_busy; i++) @(negedge clk);
    chk("a_idle_cs_busy", 32'({a_cs, a_busy}), 2);
    chk("a_cmd_ch3", 32'(a_frames[CAL+3]), 'h0300);
    chk("a_cmd_dummy", 32'(a_frames[CAL+33]), 'hE800);
    chk("a_cmd_wrap", 32'(a_frames[CAL+34]), 0);
    chk("a_frame_period", 32'(a_falls[CAL+1] - a_falls[CAL]), 74);
    chk("a_sweep_period", 32'(a_falls[CAL+34] - a_falls[CAL]), 2516);
`ifdef RHD_CALIB_EN
    chk("a_calib_cmd", 32'(a_frames[0]), 'h5500);
    chk("a_calib_dummy", 32'(a_frames[9]), 'hE800);
`endif
    chk("a_frames_total", 32'(a_frames.size()), CAL + 68);
    chk("a_words_total", 32'(a_words.size()), 64);
    chk("a_last_word", 32'(a_words[63]), 32'({1'b1, 6'd31, 16'h801F}));
    repeat (200) @(negedge clk);
    chk("a_stays_idle", 32'(a_frames.size()), CAL + 68);

    // ---- A: overflow with m_ready low for two result frames ----
    a_frames.delete();
    a_words.delete();
    ia.m_ready = 1'b0;
    a_adc_en = 1'b1;
    for (int i = 0; i < 1000 && a_frames.size() < 4; i++) @(negedge clk);
    chk("ovf_no_recal", 32'(a_frames[0]), 0);
    chk("ovf_held", 32'({ia.m_valid, ia.m_ch, ia.m_data}), 32'({1'b1, 6'd0, 16'h8000}));
    chk("ovf_flag", 32'(a_ovf), 1);
    a_adc_en = 1'b0;
    ia.m_ready = 1'b1;
    for (int i = 0; i < 1000 && a_frames.size() < 12; i++) @(negedge clk);
    chk("ovf_sticky", 32'(a_ovf), 1);
    for (int i = 0; i < 5000 && a_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("ovf_clear_idle", 32'(a_ovf), 0);
    chk("ovf_first_kept", 32'(a_words[0]), 32'({1'b0, 6'd0, 16'h8000}));
    chk("ovf_second_dropped", 32'(a_words[1]), 32'({1'b0, 6'd2, 16'h8002}));
    chk("ovf_word_count", 32'(a_words.size()), 31);

    // ---- A: reset in the middle of SHIFT ----
    a_frames.delete();
    ia.m_ready = 1'b0;
    a_adc_en = 1'b1;
    for (int i = 0; i < 1000 && a_frames.size() < 5; i++) @(negedge clk);
    for (int i = 0; i < 40 && !a_sck; i++) @(negedge clk);
    chk("pre_rst_shift", 32'({a_cs, a_sck, a_ovf, ia.m_valid}), 'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 32'({a_cs, a_sck, a_mosi, ia.m_valid, ia.m_last, a_ovf, a_busy}), 32'h40);
    chk("midrst_data", 32'({ia.m_ch, ia.m_data}), 0);
    repeat (2) @(negedge clk);
    #1;
    a_frames.delete();
    ia.m_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 500 && a_frames.size() < 1; i++) @(negedge clk);
`ifdef RHD_CALIB_EN
    chk("restart_cmd", 32'(a_frames[0]), 'h5500);
`else
    chk("restart_cmd", 32'(a_frames[0]), 0);
`endif
    a_adc_en = 1'b0;
    for (int i = 0; i < 6000 && a_busy; i++) @(negedge clk);
    chk("final_idle", 32'({a_cs, a_busy}), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
